// File: rtl/rotary_step_input_if.sv
// rotary_step_input_if: raw encoder/button inputs and decoded step/select/error outputs
// master drives the raw inputs and observes the outputs; slave is the decoder side.
interface rotary_step_input_if;
    logic enc_a;
    logic enc_b;
    logic enc_btn;
    logic step;
    logic up;
    logic select;
    logic error;
    modport master(output enc_a, enc_b, enc_btn, input step, up, select, error);
    modport slave(input enc_a, enc_b, enc_btn, output step, up, select, error);
endinterface

// File: rtl/rotary_step_input.sv
// rotary_step_input: quadrature encoder + push button front end emitting step/direction and select pulses
// Ports: clk; reset (async, active-high); bus.enc_a/enc_b/enc_btn raw asynchronous inputs;
// bus.step/select/error one-cycle pulses; bus.up direction of the last step, held between steps.
module rotary_step_input #(
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int COUNTS_PER_DETENT = 4
) (
    input logic                clk,
    input logic                reset,
    rotary_step_input_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DLAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic signed [4:0] CPD = 5'(COUNTS_PER_DETENT);
    localparam logic [0:0] PRIME = 1'b0;
    localparam logic [0:0] TRACK = 1'b1;

    // Bit order everywhere: {B, A, btn}
    logic [2:0] sync_q [SYNC_STAGES];
    logic [2:0] sync;
    logic [2:0] stable_q;
    logic [2:0] filt_q, filt_d;
    logic [2:0] prev_q, prev_d;
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];
    logic [CW-1:0] pcnt_q, pcnt_d;
    logic [0:0] state_q, state_d;
    logic signed [4:0] acc_q, acc_d, acc_n;
    logic [1:0] delta;
    logic step_q, step_d, up_q, up_d, sel_q, sel_d, err_q, err_d;

    // Gray {B,A} to position 0..3 along the forward sequence 00->01->11->10
    function automatic logic [1:0] pos(input logic [1:0] g);
        return {g[1], g[1] ^ g[0]};
    endfunction

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        pcnt_d  = '0;
        prev_d  = prev_q;
        acc_d   = acc_q;
        acc_n   = acc_q;
        delta   = '0;
        step_d  = 1'b0;
        up_d    = up_q;
        sel_d   = 1'b0;
        err_d   = 1'b0;
        filt_d  = filt_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i]  = (sync[i] == filt_q[i] || cnt_q[i] == DLAST) ? '0 : cnt_q[i] + CW'(1);
            filt_d[i] = (sync[i] != filt_q[i] && cnt_q[i] == DLAST) ? sync[i] : filt_q[i];
        end
        if (state_q == PRIME) begin
            // Wait for the synchronised inputs to sit still, then adopt them as the baseline
            pcnt_d = (sync == stable_q) ? pcnt_q + CW'(1) : '0;
            if (sync == stable_q && pcnt_q == DLAST) begin
                state_d = TRACK;
                filt_d  = sync;
                prev_d  = sync;
                pcnt_d  = '0;
                for (int i = 0; i < 3; i++) cnt_d[i] = '0;
            end
        end else begin
            prev_d = filt_q;
            delta  = pos(filt_q[2:1]) - pos(prev_q[2:1]);
            sel_d  = filt_q[0] & ~prev_q[0];
            err_d  = delta == 2'd2;
            acc_n  = acc_q + ((delta == 2'd1) ? 5'sd1 : (delta == 2'd3) ? -5'sd1 : 5'sd0);
            step_d = !err_d && (acc_n == CPD || acc_n == -CPD);
            up_d   = step_d ? (acc_n > 5'sd0) : up_q;
            acc_d  = (err_d || step_d) ? 5'sd0 : acc_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
            stable_q <= '0;
            filt_q   <= '0;
            prev_q   <= '0;
            pcnt_q   <= '0;
            state_q  <= PRIME;
            acc_q    <= '0;
            step_q   <= 1'b0;
            up_q     <= 1'b0;
            sel_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            sync_q[0] <= {bus.enc_b, bus.enc_a, bus.enc_btn};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
            stable_q <= sync;
            filt_q   <= filt_d;
            prev_q   <= prev_d;
            pcnt_q   <= pcnt_d;
            state_q  <= state_d;
            acc_q    <= acc_d;
            step_q   <= step_d;
            up_q     <= up_d;
            sel_q    <= sel_d;
            err_q    <= err_d;
        end
    end

    assign bus.step   = step_q;
    assign bus.up     = up_q;
    assign bus.select = sel_q;
    assign bus.error  = err_q;
endmodule

// File: doc/rotary_step_input.md
Name: rotary_step_input

Overview:
- Front-end producer of step/direction commands for the board-coordinate up/down counters (file/rank selection, mod-8 wrap handled downstream).
- Decodes a mechanical quadrature rotary encoder (A/B) plus push button.
- Synchronises and debounces all three inputs, then accumulates quadrature transitions into detents.
- Emits one-cycle step pulses with direction, and one-cycle select pulses on button press.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of input synchroniser (>=2).
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a filtered input changes (>=1).
- COUNTS_PER_DETENT, 4, legal quadrature transitions per emitted step (1..8).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high; clock clk.
- enc_a  input  1  raw encoder channel A, asynchronous.
- enc_b  input  1  raw encoder channel B, asynchronous.
- enc_btn  input  1  raw push button, asynchronous, active-high when pressed.
- step  output  1  one-cycle pulse: one detent completed.
- up  output  1  direction of last step; 1 = clockwise/increment; valid when step=1, held until next step.
- select  output  1  one-cycle pulse on debounced button press.
- error  output  1  one-cycle pulse on illegal quadrature transition (A and B change together).

Behaviour:
- Reset (async): all synchroniser and filter flops 0, debounce counters 0, accumulator 0, FSM = PRIME.
  - step, up, select, error all 0.
- Synchroniser: SYNC_STAGES flops per input; raw change reaches sync output after SYNC_STAGES edges.
- Debounce, per input, independent:
  - counter increments while sync value != filtered value; clears when they are equal.
  - on reaching DEBOUNCE_CYCLES, filtered <= sync value and counter clears.
  - a glitch shorter than DEBOUNCE_CYCLES cycles never changes filtered.
- FSM PRIME:
  - counts consecutive cycles in which sync {B,A,btn} is unchanged.
  - after DEBOUNCE_CYCLES such cycles, loads filtered {B,A,btn} directly from sync, sets prev_ab <= {B,A}, goes to TRACK.
  - no step/select/error in PRIME, so the encoder resting at 11 or a button held through reset produces no output.
- FSM TRACK: each cycle compares filtered {B,A} to prev_ab, then prev_ab <= filtered.
  - Forward Gray sequence 00->01->11->10->00: acc += 1.
  - Reverse sequence: acc -= 1.
  - No change: acc holds.
  - Two-bit change (00<->11, 01<->10): error=1 for one cycle, acc <= 0, no step.
- Detent accumulation:
  - acc is signed, range -COUNTS_PER_DETENT..+COUNTS_PER_DETENT.
  - On the cycle acc would reach +COUNTS_PER_DETENT: step=1, up=1, acc <= 0.
  - On the cycle acc would reach -COUNTS_PER_DETENT: step=1, up=0, acc <= 0.
  - Reversal mid-detent simply walks acc back; no step.
- Button: in TRACK, select=1 for one cycle on filtered btn 0->1; release produces nothing.
- Latency: raw edge stable thereafter -> filtered change after SYNC_STAGES + DEBOUNCE_CYCLES edges.
  - step/error/select is asserted on the next edge (total SYNC_STAGES + DEBOUNCE_CYCLES + 1).
- step and error are never both 1.
  - select is independent and may coincide with step.
- Output hold and clearing:
  - up holds its value between steps.
  - step, select and error clear to 0 the cycle after assertion.
- Reset mid-detent or mid-debounce: partial acc and counters are discarded; re-prime from current inputs.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, COUNTS_PER_DETENT=4):
- Reset with A=B=1, btn=1 held 20 cycles -> PRIME exits; step, select and error stay 0; up=0.
- Clockwise detent from 11: {B,A} 11->10->00->01->11, each held 10 cycles -> exactly one step pulse with up=1, 7 cycles after the final raw edge.
- Counter-clockwise detent 11->01->00->10->11 -> one step pulse, up=0; up remains 0 for 50 idle cycles.
- Reversal and glitch: three forward transitions, two reverse, then a 3-cycle glitch on A -> no step, no error; acc = +1 (verify via a subsequent 3 forward transitions producing a step).
- Illegal jump: filtered {B,A} 00->11 simultaneously -> error pulse of 1 cycle, no step; next full CW detent still yields exactly one step.
- Button press held 10 cycles then released -> one select pulse 7 cycles after press; none on release; assert reset mid-press -> no select after re-prime while held.
